// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the MEM-stage data-cache controller.
// The controller takes the slave view; the pipeline/memory environment takes the master view.
interface dcache_ctrl_if #(
  parameter int LINE_BITS = 256
);
  logic                 cpu_read_i;
  logic                 cpu_write_i;
  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_wdata_i;
  logic [31:0]          cpu_rdata_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_wdata_o;
  logic [LINE_BITS-1:0] mem_rdata_i;
  logic                 mem_ack_i;

  modport slave (
    input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits complete combinationally; misses run a write-back/refill FSM over a req/ack line bus.
module dcache_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = 256,
  localparam int INDEX_W  = $clog2(NUM_LINES),
  localparam int TAG_W    = 32 - 5 - INDEX_W
) (
  input logic          clk_i,
  input logic          start_i,
  dcache_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WB, RD} state_t;

  state_t               state_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic                 mem_req_reg;
  logic                 mem_write_reg;
  logic [31:0]          mem_addr_reg;
  logic [LINE_BITS-1:0] mem_wdata_reg;

  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] line_q [NUM_LINES];

  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           req_word;
  logic [7:0]           word_lsb;
  logic [LINE_BITS-1:0] line_sel;
  logic [TAG_W-1:0]     tag_sel;
  logic                 access;
  logic                 hit;
  logic                 write_hit;
  logic                 refill_en;
  logic                 unused_ok;

  assign req_index = bus.cpu_addr_i[5 +: INDEX_W];
  assign req_tag   = bus.cpu_addr_i[31 -: TAG_W];
  assign req_word  = bus.cpu_addr_i[4:2];
  assign word_lsb  = {req_word, 5'b0};
  assign unused_ok = &{1'b0, bus.cpu_addr_i[1:0]};

  assign line_sel  = line_q[req_index];
  assign tag_sel   = tag_q[req_index];
  assign access    = bus.cpu_read_i | bus.cpu_write_i;
  assign hit       = valid_reg[req_index] & (tag_sel == req_tag);
  assign write_hit = (state_reg == IDLE) & bus.cpu_write_i & hit;
  assign refill_en = (state_reg == RD) & bus.mem_ack_i;

  // A simultaneous read+write is a write, so no load data is returned for it.
  assign bus.cpu_rdata_o = ((state_reg == IDLE) && bus.cpu_read_i && !bus.cpu_write_i && hit)
                           ? line_sel[word_lsb +: 32] : 32'h0;
  assign bus.cpu_stall_o = (state_reg != IDLE) | (access & ~hit);

  assign bus.mem_req_o   = mem_req_reg;
  assign bus.mem_write_o = mem_write_reg;
  assign bus.mem_addr_o  = mem_addr_reg;
  assign bus.mem_wdata_o = mem_wdata_reg;

  // Tag and data storage carry no reset: the valid bits alone qualify them.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    logic [TAG_W-1:0]     tag_reg;
    logic [LINE_BITS-1:0] data_reg;
    logic                 sel;

    assign sel = (req_index == INDEX_W'(gi));

    always_ff @(posedge clk_i) begin
      if (refill_en && sel) begin
        tag_reg  <= req_tag;
        data_reg <= bus.mem_rdata_i;
      end else if (write_hit && sel) begin
        data_reg[word_lsb +: 32] <= bus.cpu_wdata_i;
      end
    end

    assign tag_q[gi]  = tag_reg;
    assign line_q[gi] = data_reg;
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access && !hit) begin
            mem_req_reg <= 1'b1;
            if (valid_reg[req_index] && dirty_reg[req_index]) begin
              state_reg     <= WB;
              mem_write_reg <= 1'b1;
              mem_addr_reg  <= {tag_sel, req_index, 5'b0};
              mem_wdata_reg <= line_sel;
            end else begin
              state_reg     <= RD;
              mem_write_reg <= 1'b0;
              mem_addr_reg  <= {req_tag, req_index, 5'b0};
            end
          end else begin
            mem_req_reg <= 1'b0;
            if (write_hit) begin
              dirty_reg[req_index] <= 1'b1;
            end
          end
        end
        WB: begin
          // Victim accepted: chain straight into the refill without dropping req.
          if (bus.mem_ack_i) begin
            state_reg     <= RD;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= {req_tag, req_index, 5'b0};
          end
        end
        RD: begin
          if (bus.mem_ack_i) begin
            state_reg            <= IDLE;
            mem_req_reg          <= 1'b0;
            valid_reg[req_index] <= 1'b1;
            dirty_reg[req_index] <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a scripted line memory answers requests after a fixed delay,
// and each CPU access is checked for stall length, load data and memory traffic.
module tb_dcache_ctrl;
  logic clk_i = 1'b0;
  logic start_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk_i  (clk_i),
    .start_i(start_i),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  bit [255:0]  mem_model [bit [31:0]];
  bit          mem_auto      = 1'b1;
  bit          stale_ack_req = 1'b0;
  int          ack_delay     = 10;
  int          wb_count      = 0;
  int          rd_count      = 0;
  logic [31:0] last_wb_addr  = '0;
  logic [31:0] last_rd_addr  = '0;
  logic [255:0] last_wb_data = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [255:0] line_word(input int w, input bit [31:0] v);
    bit [255:0] l;
    l = '0;
    l[w*32 +: 32] = v;
    return l;
  endfunction

  // Line memory: acks ack_delay+1 negedges after seeing a request.
  initial begin
    int wait_cnt;
    bit stale_seen;
    wait_cnt   = 0;
    stale_seen = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
        wait_cnt = 0;
      end
      if (stale_ack_req != stale_seen) begin
        stale_seen = stale_ack_req;
        if (stale_ack_req) begin
          bus.mem_rdata_i = {8{32'hBADBAD00}};
          bus.mem_ack_i   = 1'b1;
        end
      end else if (mem_auto && bus.mem_req_o) begin
        wait_cnt++;
        if (wait_cnt > ack_delay) begin
          wait_cnt = 0;
          if (bus.mem_write_o) begin
            wb_count++;
            last_wb_addr = bus.mem_addr_o;
            last_wb_data = bus.mem_wdata_o;
            mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
          end else begin
            rd_count++;
            last_rd_addr = bus.mem_addr_o;
            bus.mem_rdata_i = mem_model.exists(bus.mem_addr_o) ? mem_model[bus.mem_addr_o] : '0;
          end
          bus.mem_ack_i = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls);
    @(negedge clk_i);
    bus.cpu_read_i  = rd;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    stalls = 0;
    #1;
    while (bus.cpu_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    if (bus.cpu_stall_o) check("stall_timeout", bus.cpu_stall_o, 1'b0);
    $display("access rd=%0d wr=%0d addr=0x%08h wdata=0x%08h stalls=%0d rdata=0x%08h",
             rd, wr, addr, wdata, stalls, bus.cpu_rdata_o);
  endtask

  initial begin
    int st;
    int traffic;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int traffic;
    start_i         = 1'b1;
    bus.cpu_read_i  = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    mem_model[32'h040] = line_word(2, 32'hDEADBEEF);
    mem_model[32'h240] = line_word(1, 32'hA5A50244);
    mem_model[32'h080] = line_word(3, 32'h33333333);
    mem_model[32'h280] = line_word(0, 32'h28028028);
    mem_model[32'h0C0] = '0;
    #2 start_i = 1'b0;
    #10;
    check("rst_req",   bus.mem_req_o,   1'b0);
    check("rst_write", bus.mem_write_o, 1'b0);
    check("rst_addr",  bus.mem_addr_o,  32'h0);
    check("rst_wdata", bus.mem_wdata_o, 256'h0);
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1;

    // Clean read miss, then hit on the refilled line.
    access(1, 0, 32'h40, 0, st);
    check("miss40_stalls", st, 12);
    check("miss40_rdata", bus.cpu_rdata_o, 32'h0);
    check("miss40_rdaddr", last_rd_addr, 32'h40);
    check("miss40_nowb", wb_count, 0);
    access(1, 0, 32'h48, 0, st);
    check("hit48_stalls", st, 0);
    check("hit48_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);

    // Write hit: no traffic, then read back.
    traffic = wb_count + rd_count;
    access(0, 1, 32'h44, 32'h12345678, st);
    check("wr44_stalls", st, 0);
    check("wr44_req", bus.mem_req_o, 1'b0);
    access(1, 0, 32'h44, 0, st);
    check("rd44_stalls", st, 0);
    check("rd44_rdata", bus.cpu_rdata_o, 32'h12345678);
    check("wr44_traffic", wb_count + rd_count, traffic);

    // Dirty eviction of 0x40 by 0x244.
    access(1, 0, 32'h244, 0, st);
    check("ev244_stalls", st, 23);
    check("ev244_wbcnt", wb_count, 1);
    check("ev244_wbaddr", last_wb_addr, 32'h40);
    check("ev244_wbdata", last_wb_data, line_word(1, 32'h12345678) | line_word(2, 32'hDEADBEEF));
    check("ev244_rdaddr", last_rd_addr, 32'h240);
    check("ev244_rdata", bus.cpu_rdata_o, 32'hA5A50244);

    // Write miss to a clean line: refill only, then merge.
    access(0, 1, 32'h80, 32'h0BADF00D, st);
    check("wm80_stalls", st, 12);
    check("wm80_wbcnt", wb_count, 1);
    check("wm80_rdaddr", last_rd_addr, 32'h80);
    access(1, 0, 32'h8C, 0, st);
    check("rd8c_rdata", bus.cpu_rdata_o, 32'h33333333);
    access(1, 0, 32'h80, 0, st);
    check("rd80_rdata", bus.cpu_rdata_o, 32'h0BADF00D);
    check("rd80_stalls", st, 0);
    access(1, 0, 32'h280, 0, st);
    check("ev280_stalls", st, 23);
    check("ev280_wbaddr", last_wb_addr, 32'h80);
    check("ev280_wbdata", last_wb_data, line_word(0, 32'h0BADF00D) | line_word(3, 32'h33333333));
    check("ev280_rdata", bus.cpu_rdata_o, 32'h28028028);

    // Dirty index 4 then reset in the middle of a refill of 0x100.
    access(0, 1, 32'h284, 32'h77777777, st);
    check("wr284_stalls", st, 0);
    mem_auto = 1'b0;
    @(negedge clk_i);
    bus.cpu_read_i  = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h100;
    repeat (3) @(negedge clk_i);
    #1;
    check("midrd_req", bus.mem_req_o, 1'b1);
    check("midrd_addr", bus.mem_addr_o, 32'h100);
    check("midrd_write", bus.mem_write_o, 1'b0);
    start_i        = 1'b0;
    bus.cpu_read_i = 1'b0;
    #1;
    check("rstrd_req", bus.mem_req_o, 1'b0);
    check("rstrd_stall", bus.cpu_stall_o, 1'b0);
    check("rstrd_addr", bus.mem_addr_o, 32'h0);
    @(negedge clk_i);
    start_i = 1'b1;
    stale_ack_req = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("stale_req", bus.mem_req_o, 1'b0);
    check("stale_stall", bus.cpu_stall_o, 1'b0);
    bus.cpu_read_i = 1'b1;
    bus.cpu_addr_i = 32'h244;
    #1 check("inval244_stall", bus.cpu_stall_o, 1'b1);
    bus.cpu_addr_i = 32'h100;
    #1 check("inval100_stall", bus.cpu_stall_o, 1'b1);
    bus.cpu_addr_i = 32'h284;
    #1 check("inval284_stall", bus.cpu_stall_o, 1'b1);
    bus.cpu_read_i = 1'b0;
    #1;
    stale_ack_req = 1'b0;
    mem_auto      = 1'b1;
    traffic = wb_count;
    access(1, 0, 32'h8C, 0, st);
    check("post_rst_stalls", st, 12);
    check("post_rst_nowb", wb_count, traffic);
    check("post_rst_rdata", bus.cpu_rdata_o, 32'h33333333);

    // Back-to-back hits alternating write/read over one line.
    access(1, 0, 32'hC0, 0, st);
    check("fillc0_stalls", st, 12);
    for (int i = 0; i < 8; i++) begin
      access(0, 1, 32'hC0 + 32'(i * 4), 32'hC0DE0000 + 32'(i), st);
      check("b2b_wr_stall", st, 0);
      access(1, 0, 32'hC0 + 32'(i * 4), 0, st);
      check("b2b_rd_stall", st, 0);
      check("b2b_rd_data", bus.cpu_rdata_o, 32'hC0DE0000 + 32'(i));
    end
    access(1, 0, 32'hC4, 0, st);
    check("b2b_final_c4", bus.cpu_rdata_o, 32'hC0DE0001);

    @(negedge clk_i);
    bus.cpu_read_i  = 1'b0;
    bus.cpu_write_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- MEM-stage data-cache controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered MemRead, MemWrite, ALU result (address) and store data.
- Serves hits from an internal direct-mapped, write-back, write-allocate cache.
- On a miss, runs a write-back/refill FSM against off-chip memory with a req/ack handshake.
- Its cpu_stall_o drives the EX/MEM hold enable and the upstream stall network.

Parameters:
- NUM_LINES, 16, number of cache lines (power of two); INDEX_W = log2(NUM_LINES).
- LINE_BITS, 256, line width (32 bytes); offset field is addr[4:0], word select is addr[4:2].
- TAG_W, 23, tag width = 32 - 5 - INDEX_W.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- start_i  in  1  reset, asynchronous, active-low (negedge start_i clears state; ~start_i holds reset).
- cpu_read_i  in  1  MemRead from EX/MEM.
- cpu_write_i  in  1  MemWrite from EX/MEM.
- cpu_addr_i  in  32  byte address (ALU result); word aligned.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data, combinational, valid on read hit in IDLE; 0 otherwise.
- cpu_stall_o  out  1  combinational: high while the current access cannot complete this cycle.
- mem_req_o  out  1  registered memory request.
- mem_write_o  out  1  registered: 1 = line write-back, 0 = line read.
- mem_addr_o  out  32  registered line address, low 5 bits always 0.
- mem_wdata_o  out  256  registered victim line for write-back.
- mem_rdata_i  in  256  refill line, valid when mem_ack_i = 1.
- mem_ack_i  in  1  single-cycle completion pulse from memory.

Behaviour:
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
- Per-line state: valid, dirty, tag, 256-bit data, all held in internal registers.
- Reset (start_i low, at any time, including mid-transaction):
  - All valid and dirty bits cleared; FSM returns to IDLE.
  - mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - Any in-flight memory transaction is abandoned; a later ack is ignored in IDLE.
- access = cpu_read_i | cpu_write_i. If both are high, the access is treated as a write.
- hit = valid[index] & (tag[index] == tag).
- cpu_stall_o = (state != IDLE) | (access & ~hit).
- FSM states: IDLE, WB, RD.
- IDLE:
  - Read hit: cpu_rdata_o = data word; no state change.
  - Write hit: at the edge, update the selected word and set dirty.
  - Miss, victim valid and dirty: go to WB. mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o=victim line.
  - Miss otherwise: go to RD. mem_req_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
  - No access: outputs hold, mem_req_o=0.
- WB:
  - Hold all mem outputs until mem_ack_i is sampled high.
  - On ack, go to RD and load the refill address; mem_req_o stays 1 and mem_write_o becomes 0.
- RD:
  - Hold all mem outputs until mem_ack_i is sampled high.
  - On ack, write mem_rdata_i into the line; set valid, clear dirty, write tag.
  - mem_req_o goes 0 and the FSM returns to IDLE.
- After refill, the IDLE cycle sees a hit: stall drops that cycle.
  - Reads return data combinationally.
  - Writes merge the word and set dirty at that edge.
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: 1 + (cycles to ack) + 1.
  - Dirty miss: adds the write-back handshake.
- cpu inputs must stay stable while stalled (guaranteed by the EX/MEM hold). mem_ack_i in IDLE is ignored.

Test Plan:
- Reset, read 0x0000_0040 with ack after 10 cycles, mem_rdata_i word2 = 0xDEADBEEF:
  - Required: stall high for 12 cycles, mem_addr_o = 0x40, mem_write_o = 0.
  - Required: cpu_rdata_o = 0x0000_0000 (word 0) on completion.
  - Then read 0x48: 0xDEADBEEF, no stall.
- Write 0x1234_5678 to 0x44 (line resident):
  - Required: no stall, no mem_req_o.
  - Required: a subsequent read of 0x44 returns 0x12345678.
- Dirty eviction: after the previous step, read 0x244 (same index, tag 1):
  - Required: WB with mem_addr_o = 0x40, mem_wdata_o holding 0x12345678 in word1.
  - Required: then RD with mem_addr_o = 0x240, and final data from the refill.
- Write miss to clean line 0x80:
  - Required: RD only, no WB.
  - Required: after refill the word is merged and dirty set; evicting via 0x280 triggers WB of 0x80.
- Reset asserted mid-RD:
  - Required: mem_req_o = 0 immediately, stall low, all lines invalid.
  - Required: a stale ack pulse afterwards causes no change.
- Back-to-back hits on 8 consecutive words with read/write alternating:
  - Required: stall never asserts; read data matches the last written values.
